// File: rtl/sram_arbiter.sv
// Shares the board SRAM between the display background fetch and an auxiliary
// read/write requester; sequences address setup, OE/WE strobes and turnaround.
module sram_arbiter #(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        blank,
  input  logic        disp_req,
  input  logic [19:0] disp_addr,
  output logic        disp_gnt,
  output logic        disp_valid,
  output logic [15:0] disp_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [19:0] aux_addr,
  input  logic [15:0] aux_wdata,
  input  logic [1:0]  aux_be,
  output logic        aux_gnt,
  output logic        aux_valid,
  output logic [15:0] aux_rdata,
  output logic        aux_starved,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] RD_LAST    = CW'(READ_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST    = CW'(WRITE_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_e;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_turn_rw, w_turn_rw_nxt;
  logic          r_owner_aux;
  logic [19:0]   r_addr;
  logic [15:0]   r_wdata;
  logic [1:0]    r_be;
  logic          r_disp_gnt, r_aux_gnt, r_disp_valid, r_aux_valid;
  logic [15:0]   r_disp_rdata, r_aux_rdata;
  logic [SW-1:0] r_starve_cnt;
  logic          r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n, r_dq_oe;

  logic          w_rd_last, w_arb, w_pick_aux, w_acc_aux, w_acc_disp;
  logic [1:0]    w_be_nxt;
  logic          w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n, w_dq_oe;

  // Arbitration happens only in IDLE and on the final RD cycle; never preemptive.
  assign w_rd_last  = (r_state == RD) && (r_cnt == RD_LAST);
  assign w_arb      = (r_state == IDLE) || w_rd_last;
  assign w_pick_aux = aux_req && (!disp_req || !blank);
  assign w_acc_aux  = w_arb && w_pick_aux;
  assign w_acc_disp = w_arb && disp_req && !w_pick_aux;
  assign w_be_nxt   = w_acc_aux ? aux_be : r_be;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_turn_rw_nxt = r_turn_rw;
    unique case (r_state)
      IDLE: begin
        if (w_acc_aux && aux_we) begin
          w_state_nxt = WR;
          w_cnt_nxt   = '0;
        end else if (w_acc_aux || w_acc_disp) begin
          w_state_nxt = RD;
          w_cnt_nxt   = '0;
        end
      end
      RD: begin
        if (!w_rd_last) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else if (w_acc_aux && aux_we) begin
          w_state_nxt   = TURN;
          w_turn_rw_nxt = 1'b1;
          w_cnt_nxt     = '0;
        end else if (w_acc_aux || w_acc_disp) begin
          w_state_nxt = RD;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WR: begin
        if (r_cnt == WR_LAST) begin
          w_state_nxt   = TURN;
          w_turn_rw_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      TURN: begin
        if (r_turn_rw) begin
          w_state_nxt = WR;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pin controls are decoded from the next state and registered, so the pins never glitch.
  always_comb begin
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_ub_n  = 1'b1;
    w_lb_n  = 1'b1;
    w_dq_oe = 1'b0;
    unique case (w_state_nxt)
      RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_ub_n = 1'b0;
        w_lb_n = 1'b0;
      end
      WR: begin
        w_ce_n  = 1'b0;
        w_we_n  = 1'b0;
        w_ub_n  = ~w_be_nxt[1];
        w_lb_n  = ~w_be_nxt[0];
        w_dq_oe = 1'b1;
      end
      TURN: begin
        w_ce_n  = 1'b0;
        w_ub_n  = ~w_be_nxt[1];
        w_lb_n  = ~w_be_nxt[0];
        w_dq_oe = !w_turn_rw_nxt;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_turn_rw    <= 1'b0;
      r_owner_aux  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_disp_gnt   <= 1'b0;
      r_aux_gnt    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_aux_valid  <= 1'b0;
      r_disp_rdata <= '0;
      r_aux_rdata  <= '0;
      r_starve_cnt <= '0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_dq_oe      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_turn_rw <= w_turn_rw_nxt;

      if (w_acc_disp) begin
        r_addr      <= disp_addr;
        r_owner_aux <= 1'b0;
      end else if (w_acc_aux) begin
        r_addr      <= aux_addr;
        r_wdata     <= aux_wdata;
        r_be        <= aux_be;
        r_owner_aux <= 1'b1;
      end

      r_disp_gnt   <= w_acc_disp;
      r_aux_gnt    <= w_acc_aux;
      r_disp_valid <= w_rd_last && !r_owner_aux;
      r_aux_valid  <= w_rd_last && r_owner_aux;
      if (w_rd_last && r_owner_aux)  r_aux_rdata  <= SRAM_DQ;
      if (w_rd_last && !r_owner_aux) r_disp_rdata <= SRAM_DQ;

      if (!aux_req || w_acc_aux)        r_starve_cnt <= '0;
      else if (r_starve_cnt < STARVE_MAX) r_starve_cnt <= r_starve_cnt + SW'(1);

      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_ub_n  <= w_ub_n;
      r_lb_n  <= w_lb_n;
      r_dq_oe <= w_dq_oe;
    end
  end

  assign disp_gnt    = r_disp_gnt;
  assign disp_valid  = r_disp_valid;
  assign disp_rdata  = r_disp_rdata;
  assign aux_gnt     = r_aux_gnt;
  assign aux_valid   = r_aux_valid;
  assign aux_rdata   = r_aux_rdata;
  assign aux_starved = (r_starve_cnt >= STARVE_MAX);
  assign SRAM_ADDR   = r_addr;
  assign SRAM_DQ     = r_dq_oe ? r_wdata : 16'hzzzz;
  assign SRAM_CE_N   = r_ce_n;
  assign SRAM_OE_N   = r_oe_n;
  assign SRAM_WE_N   = r_we_n;
  assign SRAM_UB_N   = r_ub_n;
  assign SRAM_LB_N   = r_lb_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM model, read-data scoreboard queues
// and cycle-level checks of grants, strobes and bus ownership.
module tb_sram_arbiter;

  localparam int STV = 8;

  logic        clk = 1'b0;
  logic        reset_n, blank, disp_req, aux_req, aux_we;
  logic [19:0] disp_addr, aux_addr;
  logic [15:0] aux_wdata;
  logic [1:0]  aux_be;
  logic        disp_gnt, disp_valid, aux_gnt, aux_valid, aux_starved;
  logic [15:0] disp_rdata, aux_rdata;
  logic [19:0] sram_addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  tri1  [15:0] sram_dq;

  logic [15:0] mem     [0:1023];
  logic [15:0] exp_mem [0:1023];
  logic [15:0] disp_q[$];
  logic [15:0] aux_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          nd, na, first_k;
  bit          rst_done = 1'b0;
  bit          got;

  always #10 clk = ~clk;

  sram_arbiter #(.READ_CYCLES(2), .WRITE_CYCLES(2), .STARVE_LIMIT(STV)) dut (
    .Clk(clk), .Reset(reset_n), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_be(aux_be), .aux_gnt(aux_gnt), .aux_valid(aux_valid), .aux_rdata(aux_rdata),
    .aux_starved(aux_starved), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  function automatic logic [15:0] seed(input int i);
    return 16'(i * 613) ^ 16'hA5C3;
  endfunction

  // Asynchronous SRAM: drives DQ while selected and output-enabled, writes bytes while WE_N is low.
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = seed(i);
    mem[10'h123] = 16'hBEEF;
    forever begin
      @(posedge clk);
      if (!ce_n && !we_n) begin
        if (!lb_n) mem[sram_addr[9:0]][7:0]  = sram_dq[7:0];
        if (!ub_n) mem[sram_addr[9:0]][15:8] = sram_dq[15:8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the oldest expected read for that requester.
  always @(negedge clk) begin
    if (rst_done && disp_valid) begin
      if (disp_q.size() == 0) check("disp_valid_unexpected", 32'd1, 32'd0);
      else check("disp_rdata", {16'h0, disp_rdata}, {16'h0, disp_q.pop_front()});
    end
    if (rst_done && aux_valid) begin
      if (aux_q.size() == 0) check("aux_valid_unexpected", 32'd1, 32'd0);
      else check("aux_rdata", {16'h0, aux_rdata}, {16'h0, aux_q.pop_front()});
    end
  end

  task automatic aux_read(input logic [19:0] a, input string tag);
    bit g;
    g = 1'b0;
    aux_addr = a;
    aux_we   = 1'b0;
    aux_req  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (aux_gnt) begin
        g = 1'b1;
        break;
      end
    end
    check(tag, {31'h0, g}, 32'd1);
    if (g) aux_q.push_back(exp_mem[a[9:0]]);
    aux_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; blank = 1'b1; disp_req = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
    disp_addr = '0; aux_addr = '0; aux_wdata = '0; aux_be = '0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = seed(i);
    exp_mem[10'h123] = 16'hBEEF;

    // Reset state
    repeat (3) tick();
    check("rst_ctrl", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("rst_addr", sram_addr, 20'h0);
    check("rst_dq_released", sram_dq, 16'hFFFF);
    check("rst_flags", {disp_gnt, aux_gnt, disp_valid, aux_valid, aux_starved}, 5'b0);
    check("rst_rdata", {disp_rdata, aux_rdata}, 32'h0);
    reset_n = 1'b1;
    rst_done = 1'b1;
    tick();

    // Single display read
    disp_addr = 20'h00123; disp_req = 1'b1;
    tick();
    check("rd_gnt", disp_gnt, 1'b1);
    check("rd_oe_low", {ce_n, oe_n, we_n}, 3'b001);
    check("rd_addr", sram_addr, 20'h00123);
    disp_q.push_back(exp_mem[10'h123]);
    disp_req = 1'b0;
    tick();
    check("rd_gnt_pulse", disp_gnt, 1'b0);
    check("rd_oe_held", oe_n, 1'b0);
    check("rd_no_early_valid", disp_valid, 1'b0);
    tick();
    check("rd_valid", disp_valid, 1'b1);
    check("rd_oe_released", oe_n, 1'b1);
    tick();
    check("rd_valid_pulse", disp_valid, 1'b0);
    check("rd_rdata_hold", disp_rdata, 16'hBEEF);

    // Reset during the first RD cycle
    disp_addr = 20'h00045; disp_req = 1'b1;
    tick();
    check("mr_gnt", disp_gnt, 1'b1);
    reset_n = 1'b0; disp_req = 1'b0;
    tick();
    check("mr_ctrl", {ce_n, oe_n}, 2'b11);
    check("mr_dq_released", sram_dq, 16'hFFFF);
    check("mr_no_valid", disp_valid, 1'b0);
    check("mr_rdata_cleared", disp_rdata, 16'h0);
    reset_n = 1'b1;
    tick();
    check("mr_no_late_valid", disp_valid, 1'b0);
    tick();

    // Contention in active video: display wins every arbitration
    blank = 1'b1; disp_addr = 20'h00100; disp_req = 1'b1;
    aux_addr = 20'h00200; aux_we = 1'b0; aux_req = 1'b1;
    nd = 0; na = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (disp_gnt) begin
        nd++;
        disp_q.push_back(exp_mem[disp_addr[9:0]]);
        disp_addr = disp_addr + 20'h1;
      end
      if (aux_gnt) na++;
      check("starve_flag", aux_starved, (i >= STV) ? 1'b1 : 1'b0);
    end
    check("active_disp_grants", nd, 10);
    check("active_aux_grants", na, 0);

    // Display withdraws: the lone aux request wins at the next arbitration
    disp_req = 1'b0; blank = 1'b0;
    got = 1'b0; first_k = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (aux_gnt) begin
        got = 1'b1;
        first_k = k;
        break;
      end
    end
    check("aux_gnt_after_disp", {31'h0, got}, 32'd1);
    check("aux_gnt_latency", first_k, 0);
    check("starve_cleared_on_gnt", aux_starved, 1'b0);
    aux_q.push_back(exp_mem[10'h200]);
    aux_req = 1'b0;
    repeat (4) tick();

    // Contention in blanking: aux byte write first, then display after one IDLE cycle
    blank = 1'b0; disp_addr = 20'h00300; disp_req = 1'b1;
    aux_addr = 20'h00010; aux_we = 1'b1; aux_wdata = 16'h5A5A; aux_be = 2'b01; aux_req = 1'b1;
    exp_mem[10'h010][7:0] = 8'h5A;
    tick();
    check("blk_aux_gnt", {aux_gnt, disp_gnt}, 2'b10);
    check("blk_wr_ctrl", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b01010);
    check("blk_wr_dq", sram_dq, 16'h5A5A);
    check("blk_wr_addr", sram_addr, 20'h00010);
    aux_req = 1'b0;
    tick();
    check("blk_we_second", we_n, 1'b0);
    tick();
    check("blk_turn_ctrl", {oe_n, we_n}, 2'b11);
    check("blk_turn_hold", sram_dq, 16'h5A5A);
    tick();
    check("blk_idle_ce", ce_n, 1'b1);
    check("blk_idle_dq", sram_dq, 16'hFFFF);
    check("blk_no_early_disp", disp_gnt, 1'b0);
    tick();
    check("blk_disp_gnt", disp_gnt, 1'b1);
    disp_q.push_back(exp_mem[10'h300]);
    disp_req = 1'b0;
    repeat (3) tick();

    // Read followed by pending write: one TURN cycle with the bus released
    blank = 1'b1; disp_addr = 20'h00050; disp_req = 1'b1;
    tick();
    check("rw_disp_gnt", disp_gnt, 1'b1);
    disp_q.push_back(exp_mem[10'h050]);
    disp_req = 1'b0;
    aux_addr = 20'h00060; aux_we = 1'b1; aux_wdata = 16'h1234; aux_be = 2'b11; aux_req = 1'b1;
    exp_mem[10'h060] = 16'h1234;
    tick();
    check("rw_last_rd", oe_n, 1'b0);
    tick();
    check("rw_aux_gnt", aux_gnt, 1'b1);
    check("rw_turn_ctrl", {oe_n, we_n}, 2'b11);
    check("rw_turn_dq_z", sram_dq, 16'hFFFF);
    aux_req = 1'b0;
    tick();
    check("rw_we_fall", we_n, 1'b0);
    check("rw_wr_dq", sram_dq, 16'h1234);
    tick();
    check("rw_we_second", we_n, 1'b0);
    tick();
    check("rw_post_turn", {we_n, sram_dq}, {1'b1, 16'h1234});
    tick();
    check("rw_idle", ce_n, 1'b1);
    tick();

    // Aux request withdrawn during a display read
    blank = 1'b1; disp_addr = 20'h00070; disp_req = 1'b1;
    tick();
    check("wd_disp_gnt", disp_gnt, 1'b1);
    disp_q.push_back(exp_mem[10'h070]);
    disp_req = 1'b0;
    aux_addr = 20'h00080; aux_we = 1'b0; aux_req = 1'b1;
    tick();
    check("wd_no_aux_gnt1", aux_gnt, 1'b0);
    aux_req = 1'b0;
    tick();
    check("wd_no_aux_gnt2", aux_gnt, 1'b0);
    tick();
    check("wd_idle", {aux_gnt, ce_n}, 2'b01);
    check("wd_addr_untouched", sram_addr, 20'h00070);
    check("wd_no_starve", aux_starved, 1'b0);
    tick();

    // Read back written words through the aux port
    aux_read(20'h00010, "rb_gnt_partial");
    aux_read(20'h00060, "rb_gnt_full");
    repeat (3) tick();
    check("disp_q_drained", disp_q.size(), 0);
    check("aux_q_drained", aux_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
